button_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of `regfile_top`'s button logic. It takes raw, asynchronous, bouncing push-button levels and synchronizes each one to `clk`. Each button is debounced independently. The block presents a clean level plus single-cycle press and release strobes, which the downstream datapath consumes as its load, execute and readback commands.

---
 rtl/button_conditioner.sv | 81 ++++++++
 tb/tb_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-flop synchronizer plus stability-count
// debouncer for raw push-button levels. Presents a clean level and one-cycle
// press/release strobes. Every output is taken directly from a register.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // The counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Per channel: count consecutive cycles where the synchronized input
    // disagrees with the accepted level. Any agreeing cycle discards the
    // partial count; reaching the limit accepts the new level and fires
    // the matching strobe for one cycle.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // State registers; reset clears synchronizer, counters, level and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (DEBOUNCE_CYCLES=4 and =1) share
// one stimulus stream. A window-based model predicts every output each cycle,
// directed scenarios pin literal values, and random traffic exercises the
// strobe invariants.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = 4'b0000;
    logic [3:0] lvl4, prs4, rel4;
    logic [3:0] lvl1, prs1, rel1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl4), .btn_press(prs4), .btn_release(rel4)
    );

    button_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A level is accepted at edge t when the synchronized input seen at the
    // last D edges all differ from the current level, and none of those edges
    // is at or before the previous accept or reset.
    int         DC [2] = '{4, 1};
    logic [3:0] in_h [$];
    bit         rs_h [$];
    logic [3:0] m_lvl [2];
    logic [3:0] m_prs [2];
    logic [3:0] m_rel [2];
    int         last_evt [2][4];
    int         t = 0;
    bit         model_valid = 1'b0;

    // Value the second synchronizer flop holds just before edge k.
    function automatic logic s2_before(input int k, input int i);
        if (k < 2) return 1'b0;
        if (rs_h[k-1] || rs_h[k-2]) return 1'b0;
        return in_h[k-2][i];
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_lvl[c] = '0; m_prs[c] = '0; m_rel[c] = '0;
            for (int i = 0; i < 4; i++) last_evt[c][i] = 0;
        end
        forever begin
            @(posedge clk);
            in_h.push_back(btn_in);
            rs_h.push_back(rst);
            for (int c = 0; c < 2; c++) begin
                m_prs[c] = '0;
                m_rel[c] = '0;
                for (int i = 0; i < 4; i++) begin
                    if (rs_h[t]) begin
                        m_lvl[c][i] = 1'b0;
                        last_evt[c][i] = t;
                    end else begin
                        bit acc;
                        acc = (t - last_evt[c][i] >= DC[c]);
                        for (int k = t - DC[c] + 1; k <= t; k++) begin
                            if (k < 0 || s2_before(k, i) == m_lvl[c][i]) acc = 1'b0;
                        end
                        if (acc) begin
                            m_lvl[c][i] = ~m_lvl[c][i];
                            m_prs[c][i] = m_lvl[c][i];
                            m_rel[c][i] = ~m_lvl[c][i];
                            last_evt[c][i] = t;
                        end
                    end
                end
            end
            t++;
            model_valid = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    logic [3:0] prev_prs [2];
    logic [3:0] prev_rel [2];
    logic [3:0] par [2];
    int         last_kind [2][4];   // 1 = press, 2 = release

    initial begin
        for (int c = 0; c < 2; c++) begin
            prev_prs[c] = '0; prev_rel[c] = '0; par[c] = '0;
            for (int i = 0; i < 4; i++) last_kind[c][i] = 2;
        end
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int c = 0; c < 2; c++) begin
                    logic [3:0] l, p, r;
                    l = (c == 0) ? lvl4 : lvl1;
                    p = (c == 0) ? prs4 : prs1;
                    r = (c == 0) ? rel4 : rel1;
                    chk($sformatf("model_level_d%0d", DC[c]), l, m_lvl[c]);
                    chk($sformatf("model_press_d%0d", DC[c]), p, m_prs[c]);
                    chk($sformatf("model_release_d%0d", DC[c]), r, m_rel[c]);
                    if (rs_h[t-1]) begin
                        prev_prs[c] = '0; prev_rel[c] = '0; par[c] = '0;
                        for (int i = 0; i < 4; i++) last_kind[c][i] = 2;
                    end else begin
                        chk($sformatf("excl_d%0d", DC[c]), p & r, 4'b0000);
                        chk($sformatf("press_1cyc_d%0d", DC[c]), p & prev_prs[c], 4'b0000);
                        chk($sformatf("rel_1cyc_d%0d", DC[c]), r & prev_rel[c], 4'b0000);
                        for (int i = 0; i < 4; i++) begin
                            if (p[i]) begin
                                if (last_kind[c][i] == 1) begin
                                    errors++;
                                    $display("FAIL alternate_d%0d ch%0d: got press after press, expected release", DC[c], i);
                                end
                                checks++;
                                last_kind[c][i] = 1;
                            end
                            if (r[i]) begin
                                if (last_kind[c][i] == 2) begin
                                    errors++;
                                    $display("FAIL alternate_d%0d ch%0d: got release after release, expected press", DC[c], i);
                                end
                                checks++;
                                last_kind[c][i] = 2;
                            end
                        end
                        par[c] = par[c] ^ p ^ r;
                        chk($sformatf("parity_d%0d", DC[c]), l, par[c]);
                        prev_prs[c] = p;
                        prev_rel[c] = r;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Apply v just after an edge; returns 2 time units after the next edge.
    task automatic step(input logic [3:0] v);
        btn_in = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] v;
        bit bounce [11] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0};

        // Reset state
        rst = 1'b1;
        btn_in = 4'b0000;
        repeat (3) begin @(posedge clk); #2; end
        chk("rst_level4", lvl4, 4'b0000);
        chk("rst_press4", prs4, 4'b0000);
        chk("rst_release4", rel4, 4'b0000);
        chk("rst_level1", lvl1, 4'b0000);
        rst = 1'b0;
        repeat (3) step(4'b0000);

        // 1. Clean press then release on channel 0
        step(4'b0001);                         // E0
        repeat (4) step(4'b0001);              // E1..E4
        chk("t1_level_E4", lvl4, 4'b0000);
        chk("t1_press_E4", prs4, 4'b0000);
        step(4'b0001);                         // E5
        chk("t1_level_E5", lvl4, 4'b0001);
        chk("t1_press_E5", prs4, 4'b0001);
        step(4'b0001);                         // E6
        chk("t1_press_E6", prs4, 4'b0000);
        repeat (6) step(4'b0001);
        step(4'b0000);                         // E0 of drop
        repeat (4) step(4'b0000);
        chk("t1_level_drop_E4", lvl4, 4'b0001);
        chk("t1_release_drop_E4", rel4, 4'b0000);
        step(4'b0000);                         // E5
        chk("t1_level_drop_E5", lvl4, 4'b0000);
        chk("t1_release_drop_E5", rel4, 4'b0001);
        step(4'b0000);
        chk("t1_release_drop_E6", rel4, 4'b0000);

        // 2. Bounce rejection on channel 1
        foreach (bounce[k]) begin
            step(bounce[k] ? 4'b0010 : 4'b0000);
            chk("t2_bounce_level", lvl4, 4'b0000);
            chk("t2_bounce_strobe", prs4 | rel4, 4'b0000);
        end
        repeat (6) step(4'b0000);
        chk("t2_settle_level", lvl4, 4'b0000);
        step(4'b0010);                         // E0
        repeat (4) step(4'b0010);              // E4
        chk("t2_press_E4", prs4, 4'b0000);
        step(4'b0010);                         // E5
        chk("t2_press_E5", prs4, 4'b0010);

        // 3. Simultaneous press on channels 1 and 3
        repeat (8) step(4'b0000);
        step(4'b1010);
        repeat (4) step(4'b1010);
        chk("t3_press_E4", prs4, 4'b0000);
        step(4'b1010);
        chk("t3_press_E5", prs4, 4'b1010);
        chk("t3_level_E5", lvl4, 4'b1010);
        step(4'b1010);
        chk("t3_press_E6", prs4, 4'b0000);

        // 4. Reset in the middle of a count on channel 2
        repeat (8) step(4'b0000);
        step(4'b0100);                         // E0
        step(4'b0100);                         // E1
        step(4'b0100);                         // E2
        rst = 1'b1;
        step(4'b0100);                         // E3 with reset
        chk("t4_rst_level4", lvl4, 4'b0000);
        chk("t4_rst_strobe4", prs4 | rel4, 4'b0000);
        chk("t4_rst_level1", lvl1, 4'b0000);
        chk("t4_rst_strobe1", prs1 | rel1, 4'b0000);
        rst = 1'b0;
        step(4'b0100);                         // E0 after reset
        repeat (4) step(4'b0100);
        chk("t4_press_E4", prs4, 4'b0000);
        step(4'b0100);
        chk("t4_press_E5", prs4, 4'b0100);

        // 5. Minimum filter (DEBOUNCE_CYCLES=1) on channel 3
        repeat (8) step(4'b0000);
        step(4'b1000);                         // E0
        chk("t5_press_E0", prs1, 4'b0000);
        step(4'b1000);                         // E1
        chk("t5_press_E1", prs1, 4'b0000);
        step(4'b1000);                         // E2
        chk("t5_press_E2", prs1, 4'b1000);
        chk("t5_level_E2", lvl1, 4'b1000);
        repeat (3) step(4'b1000);
        step(4'b0000);                         // glitch sampled at E0
        step(4'b1000);                         // E1
        chk("t5_glitch_rel_E1", rel1, 4'b0000);
        step(4'b1000);                         // E2
        chk("t5_glitch_rel_E2", rel1, 4'b1000);
        chk("t5_glitch_level_E2", lvl1, 4'b0000);
        step(4'b1000);                         // E3
        chk("t5_glitch_press_E3", prs1, 4'b1000);

        // 6. Random traffic with occasional reset
        v = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
            end
            rst = ($urandom_range(0, 299) == 0);
            step(v);
        end
        rst = 1'b0;
        repeat (10) step(4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
